// File: rtl/set_ctrl.sv
`default_nettype none
// =============================================================================
// set_ctrl : clock time-set controller (debounced mode/adjust buttons,
//            auto-repeat, blink mask and idle timeout)
// Revision : 1.0
// =============================================================================
module set_ctrl #(
    parameter int DEB_TICKS     = 4,
    parameter int REPEAT_TICKS  = 8,
    parameter int BLINK_TICKS   = 16,
    parameter int TIMEOUT_TICKS = 64
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_tick,
    input  logic       i_btn_mode,
    input  logic       i_btn_adj,
    output logic       o_run_en,
    output logic       o_inc_hr,
    output logic       o_inc_min,
    output logic       o_clr_sec,
    output logic [1:0] o_blank,
    output logic [1:0] o_mode
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2,
        ST_BAD     = 2'd3
    } state_t;

    localparam int c_DW = $clog2(DEB_TICKS + 1);
    localparam int c_RW = $clog2(REPEAT_TICKS + 1);
    localparam int c_BW = $clog2(BLINK_TICKS + 1);
    localparam int c_TW = $clog2(TIMEOUT_TICKS + 1);

    localparam logic [c_DW-1:0] c_DEB_LAST = c_DW'(DEB_TICKS - 1);
    localparam logic [c_RW-1:0] c_REP_LAST = c_RW'(REPEAT_TICKS - 1);
    localparam logic [c_BW-1:0] c_BLK_LAST = c_BW'(BLINK_TICKS - 1);
    localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(TIMEOUT_TICKS - 1);

    logic [1:0] w_raw;
    logic [1:0] w_press;
    logic [1:0] w_stable;

    assign w_raw = {i_btn_adj, i_btn_mode};

    // index 0 = mode button, index 1 = adjust button
    generate
        for (genvar g = 0; g < 2; g++) begin : g_deb
            logic            r_s1;
            logic            r_s2;
            logic            r_stable;
            logic            r_press;
            logic [c_DW-1:0] r_cnt;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_s1     <= 1'b0;
                    r_s2     <= 1'b0;
                    r_stable <= 1'b0;
                    r_press  <= 1'b0;
                    r_cnt    <= '0;
                end else begin
                    r_s1    <= w_raw[g];
                    r_s2    <= r_s1;
                    r_press <= 1'b0;
                    if (i_tick) begin
                        if (r_s2 == r_stable) begin
                            r_cnt <= '0;
                        end else if (r_cnt == c_DEB_LAST) begin
                            r_stable <= r_s2;
                            r_cnt    <= '0;
                            r_press  <= r_s2;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
            end

            assign w_press[g]  = r_press;
            assign w_stable[g] = r_stable;
        end
    endgenerate

    state_t          r_state;
    state_t          w_next;
    logic [c_RW-1:0] r_rep_cnt;
    logic [c_TW-1:0] r_tmo_cnt;
    logic [c_BW-1:0] r_blk_cnt;
    logic            r_phase;
    logic            r_inc_hr;
    logic            r_inc_min;
    logic            r_clr_sec;

    logic w_mode_p;
    logic w_adj_p;
    logic w_adj_hi;
    logic w_in_set;
    logic w_tmo_fire;
    logic w_rep_fire;
    logic w_state_chg;
    logic w_inc_hr;
    logic w_inc_min;
    logic w_clr_sec;

    assign w_mode_p    = w_press[0];
    assign w_adj_p     = w_press[1];
    assign w_adj_hi    = w_stable[1];
    assign w_in_set    = (r_state == ST_SET_HR) || (r_state == ST_SET_MIN);
    assign w_tmo_fire  = w_in_set && i_tick && !(|w_press) && (r_tmo_cnt == c_TMO_LAST);
    assign w_rep_fire  = w_in_set && i_tick && w_adj_hi && !w_adj_p && (r_rep_cnt == c_REP_LAST);
    assign w_state_chg = (w_next != r_state);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next;
        end
    end

    // Mode press outranks timeout and increments; a simultaneous adj press is dropped.
    always_comb begin
        w_next    = r_state;
        w_inc_hr  = 1'b0;
        w_inc_min = 1'b0;
        w_clr_sec = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_mode_p) w_next = ST_SET_HR;
            end
            ST_SET_HR: begin
                if (w_mode_p)                    w_next   = ST_SET_MIN;
                else if (w_tmo_fire)             w_next   = ST_RUN;
                else if (w_adj_p || w_rep_fire)  w_inc_hr = 1'b1;
            end
            ST_SET_MIN: begin
                if (w_mode_p) begin
                    w_next    = ST_RUN;
                    w_clr_sec = 1'b1;
                end else if (w_tmo_fire) begin
                    w_next = ST_RUN;
                end else if (w_adj_p || w_rep_fire) begin
                    w_inc_min = 1'b1;
                end
            end
            default: w_next = ST_RUN;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rep_cnt <= '0;
            r_tmo_cnt <= '0;
            r_blk_cnt <= '0;
            r_phase   <= 1'b0;
        end else if (w_state_chg || !w_in_set) begin
            r_rep_cnt <= '0;
            r_tmo_cnt <= '0;
            r_blk_cnt <= '0;
            r_phase   <= 1'b0;
        end else begin
            if (w_adj_p || !w_adj_hi)  r_rep_cnt <= '0;
            else if (i_tick)           r_rep_cnt <= w_rep_fire ? '0 : r_rep_cnt + 1'b1;

            if (|w_press)              r_tmo_cnt <= '0;
            else if (i_tick)           r_tmo_cnt <= r_tmo_cnt + 1'b1;

            if (i_tick) begin
                if (r_blk_cnt == c_BLK_LAST) begin
                    r_blk_cnt <= '0;
                    r_phase   <= ~r_phase;
                end else begin
                    r_blk_cnt <= r_blk_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_inc_hr  <= 1'b0;
            r_inc_min <= 1'b0;
            r_clr_sec <= 1'b0;
        end else begin
            r_inc_hr  <= w_inc_hr;
            r_inc_min <= w_inc_min;
            r_clr_sec <= w_clr_sec;
        end
    end

    assign o_run_en  = (r_state == ST_RUN);
    assign o_mode    = r_state;
    assign o_inc_hr  = r_inc_hr;
    assign o_inc_min = r_inc_min;
    assign o_clr_sec = r_clr_sec;
    assign o_blank   = w_adj_hi ? 2'b00
                     : {r_phase & (r_state == ST_SET_HR), r_phase & (r_state == ST_SET_MIN)};

endmodule
`default_nettype wire

// File: doc/set_ctrl.md
SET_CTRL -- requirements
Module: set_ctrl

Interface
REQ-001 SHALL have parameter DEB_TICKS, default 4: consecutive differing tick samples needed to accept a new button level.
REQ-002 SHALL have parameter REPEAT_TICKS, default 8: ticks per auto-repeat interval.
REQ-003 SHALL have parameter BLINK_TICKS, default 16: ticks per blink phase.
REQ-004 SHALL have parameter TIMEOUT_TICKS, default 64: idle ticks before a set state is abandoned.
REQ-005 SHALL have port i_clk, input, 1, sole clock; all state on rising edge.
REQ-006 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port i_tick, input, 1, one-cycle prescaler strobe used for all timing.
REQ-008 SHALL have port i_btn_mode, input, 1, raw asynchronous mode button, active-high.
REQ-009 SHALL have port i_btn_adj, input, 1, raw asynchronous adjust button, active-high.
REQ-010 SHALL have port o_run_en, output, 1, time counters may advance.
REQ-011 SHALL have port o_inc_hr, output, 1, one-cycle hour-increment pulse.
REQ-012 SHALL have port o_inc_min, output, 1, one-cycle minute-increment pulse.
REQ-013 SHALL have port o_clr_sec, output, 1, one-cycle seconds-clear pulse.
REQ-014 SHALL have port o_blank, output, 2, display blank mask: bit1 hours, bit0 minutes.
REQ-015 SHALL have port o_mode, output, 2, current state encoding.

Function
REQ-016 Each button SHALL pass through a two-flop synchronizer before any other use.
REQ-017 Per button, on each i_tick: sample equal to stable level clears the debounce count; sample different increments it; reaching DEB_TICKS updates stable level and clears the count.
REQ-018 A press event SHALL be a stable-level 0->1 update, one cycle wide; releases generate no event.
REQ-019 States SHALL be RUN=0, SET_HR=1, SET_MIN=2; encoding 3 SHALL go to RUN next cycle.
REQ-020 Mode press SHALL move RUN->SET_HR, SET_HR->SET_MIN, SET_MIN->RUN.
REQ-021 SET_MIN->RUN via mode press SHALL assert o_clr_sec on the cycle after the press event.
REQ-022 Adj press SHALL assert o_inc_hr (SET_HR) or o_inc_min (SET_MIN) on the cycle after the press event; ignored in RUN.
REQ-023 While adj stable-high in a set state, the tick count since press SHALL produce one further increment pulse each time it reaches a multiple of REPEAT_TICKS (first at REPEAT_TICKS).
REQ-024 Simultaneous mode and adj press events SHALL perform the mode transition only, with no increment and repeat count cleared.
REQ-025 Any state change SHALL clear repeat, blink and timeout counters and blink phase.
REQ-026 o_run_en SHALL be 1 exactly in RUN; o_mode SHALL equal state.
REQ-027 In set states blink phase SHALL toggle every BLINK_TICKS ticks; o_blank[1]=phase&SET_HR, o_blank[0]=phase&SET_MIN; o_blank=0 while adj stable-high.
REQ-028 In set states the timeout counter SHALL count ticks, clear on any press event, and at TIMEOUT_TICKS force RUN without o_clr_sec.
REQ-029 At most one of o_inc_hr, o_inc_min, o_clr_sec SHALL be high in any cycle; all outputs registered or decoded from registered state only.
REQ-030 All counters SHALL be wide enough for their parameter with no wrap before terminal count.

Reset
REQ-031 i_rst_n low SHALL immediately, independent of i_clk, set state RUN, all counters, synchronizers, stable levels and blink phase to 0.
REQ-032 During reset outputs SHALL be o_run_en=1, o_inc_hr=0, o_inc_min=0, o_clr_sec=0, o_blank=0, o_mode=0.
REQ-033 Reset mid-sequence SHALL discard pending pulses; a button held through reset release SHALL yield a press event after DEB_TICKS ticks.

Verification (defaults, i_tick every 4 clocks)
REQ-034 Mode held 3 ticks then released -> no event, o_mode stays 0; held 4 ticks -> o_mode=1, o_run_en=0.
REQ-035 Three clean mode presses from RUN -> o_mode 1,2,0; exactly one o_clr_sec pulse, on the SET_MIN->RUN transition.
REQ-036 In SET_HR, adj held 40 ticks past debounce -> o_inc_hr pulses = 1 + 5 = 6, o_blank=0 throughout hold.
REQ-037 In SET_MIN, idle 64 ticks -> o_mode=0, o_run_en=1, no o_clr_sec; blank toggled at ticks 16,32,48.
REQ-038 Mode and adj press events forced same cycle in SET_HR -> o_mode=2, no o_inc_hr.
REQ-039 i_rst_n low mid-repeat in SET_HR -> same-cycle o_mode=0, o_run_en=1, no further pulses.
